// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch sequencer: FSM state encoding and
// fetch-buffer entry layout.
package imem_fetch_ctrl_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_fifo.sv
// Fetch buffer: synchronous FIFO with flush, count output, push-while-full
// when popping, and a registered head that holds its value when empty.
module imem_fetch_ctrl_fetch_fifo
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     head_q;
  logic             valid_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             do_pop;
  logic             do_push;
  logic             bypass;

  always_comb begin
    do_pop     = pop && (count_q != '0);
    do_push    = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    rd_ptr_nxt = rd_ptr_q + PTR_W'(do_pop);
    count_nxt  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    // Buffer would be empty without this push: the new entry becomes the head.
    bypass     = do_push && (count_q == CNT_W'(do_pop));
  end

  // Storage array; entries are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
      valid_q  <= (count_nxt != '0);
      if (bypass) begin
        head_q <= push_data;
      end else if (count_nxt != '0) begin
        head_q <= mem_q[rd_ptr_nxt];
      end
    end
  end

  assign head       = head_q;
  assign head_valid = valid_q;
  assign count      = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, fetches into a small buffer and
// hands words to decode. IMEM_FETCH_PERF_EN adds fetch/stall counters.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               halt,
  output logic               addr_err
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e     state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic              addr_err_q;
  logic              pop;
  logic              push_ok;
  logic              push;
  logic              target_ok;
  logic [CNT_W-1:0]  buf_count;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  always_comb begin
    pop              = out_valid && out_ready;
    push_ok          = (buf_count < CNT_W'(BUF_DEPTH)) || pop;
    push             = (state_q == FETCH) && !redirect_valid && push_ok;
    pc_inc           = (pc_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : pc_q + ADDR_W'(1);
    target_ok        = (redirect_target < ADDR_W'(MEM_DEPTH));
    push_entry.pc    = PC_W'(pc_q);
    push_entry.instr = imem_rdata;
  end

  // Sequencer FSM plus PC; a redirect overrides any increment in its cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= ADDR_W'(RESET_PC);
      addr_err_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT:    state_q <= halt ? HALT : FETCH;
        FETCH:   if (halt) state_q <= HALT;
        HALT:    if (!halt) state_q <= FETCH;
        default: state_q <= BOOT;
      endcase
      if (redirect_valid) begin
        if (target_ok) begin
          pc_q <= redirect_target;
        end else begin
          pc_q       <= ADDR_W'(RESET_PC);
          addr_err_q <= 1'b1;
        end
      end else if (push) begin
        pc_q <= pc_inc;
      end
    end
  end

  imem_fetch_ctrl_fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head       (head_entry),
    .head_valid (out_valid),
    .count      (buf_count)
  );

  assign imem_addr = pc_q;
  assign out_instr = head_entry.instr;
  assign out_pc    = ADDR_W'(head_entry.pc);
  assign addr_err  = addr_err_q;

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Stall counts only cycles where a full buffer, not a redirect, blocked the push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if ((state_q == FETCH) && !redirect_valid && !push_ok) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch sequencer for the word-indexed, combinational instruction memory. Owns the PC and drives the memory address.
- Buffers fetched words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts jump/branch redirects from execute and a halt request.
- Sits between the instruction memory and the decode/control stage of the single-cycle/multicycle core.

Parameters:
- ADDR_W, 32, width of PC and memory index.
- MEM_DEPTH, 32, number of instruction words; the valid index range is 0..MEM_DEPTH-1.
- RESET_PC, 0, PC value after reset and after an address error.
- BUF_DEPTH, 2, fetch buffer entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  ADDR_W  word index to the instruction memory; equals the current PC.
- imem_rdata  in  32  combinational memory data for imem_addr.
- out_instr  out  32  instruction at the buffer head.
- out_pc  out  ADDR_W  PC of out_instr.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  decode accepts the head when out_valid is also high.
- redirect_valid  in  1  one-cycle pulse: jump/branch taken.
- redirect_target  in  ADDR_W  new word index.
- halt  in  1  level: stop issuing new fetches.
- addr_err  out  1  sticky flag: a redirect target was ≥ MEM_DEPTH.

Behaviour:
- Reset (asynchronous, active-high clk/rst):
  - pc=RESET_PC, buffer count=0, out_valid=0, out_instr=0, out_pc=0, addr_err=0.
  - state=BOOT.
- States:
  - BOOT: one cycle with no fetch (memory output settles), then →FETCH; →HALT if halt is high.
  - FETCH: on each cycle where push is allowed, write {pc, imem_rdata} to the buffer tail and set pc ← pc+1. Wrap from MEM_DEPTH-1 to 0. →HALT when halt is high.
  - HALT: no pushes; the buffer drains normally. →FETCH when halt falls.
- Push allowed when count<BUF_DEPTH, or count==BUF_DEPTH with a pop in the same cycle.
- Pop: out_valid && out_ready. The head advances at the clock edge.
- Empty and full:
  - Empty: out_valid=0; out_instr and out_pc hold their last values.
  - Full with no pop: pc holds and imem_addr is stable.
- Latency: a word at pc is visible on out_instr one cycle after push, so first out_valid appears 2 cycles after reset release (BOOT + 1 push).
- Redirect (highest priority, in any state except during reset):
  - Flush the buffer (count=0); out_valid=0 next cycle.
  - A pop in the same cycle is still counted as accepted by decode.
  - No push that cycle.
  - If redirect_target < MEM_DEPTH: pc ← target. Otherwise pc ← RESET_PC and addr_err ← 1. addr_err clears only on reset.
  - Redirect in HALT updates pc but stays in HALT.
- halt rising in the same cycle as a push: that push completes; fetching stops from the next cycle.
- rst asserted mid-operation: everything returns to reset values immediately, with no partial pushes.
- pc arithmetic is modulo MEM_DEPTH. imem_addr upper bits above clog2(MEM_DEPTH) are always 0.

Optional Feature:
- IMEM_FETCH_PERF_EN defined: adds two output ports, fetch_cnt[31:0] and stall_cnt[31:0].
  - fetch_cnt counts pushes.
  - stall_cnt counts FETCH-state cycles where a push was blocked by a full buffer.
  - Both counters reset to 0, wrap at 2^32, and are unaffected by redirect.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encoding (BOOT, FETCH, HALT) and the fetch-buffer entry struct {pc, instr}.
- Shared package constant: INSTR_W=32.
- One sub-module: fetch_fifo, a parameterised synchronous FIFO with flush, count output, and simultaneous push/pop when full. The FSM and pc logic stay in the top module.

Test Plan:
- Reset then out_ready=1 with mem[0]=0x00000000, mem[1]=0x00614020: out_valid first high 2 cycles after rst release. Sequence: out_pc=0, instr 0x00000000; then out_pc=1, instr 0x00614020; then one per cycle.
- out_ready=0 for 5 cycles: count saturates at 2, pc holds at 2 and imem_addr stays 2. Releasing out_ready delivers pc 0,1,2 in order with no loss or duplicate.
- Fetch through index 31 with out_ready=1: the next out_pc is 0, confirming wrap.
- redirect_valid pulse with target=12 while the buffer holds 2 entries: out_valid=0 next cycle, then out_pc=12, 13. addr_err stays 0.
- redirect target=40 (MEM_DEPTH=32): addr_err=1 and persists, next out_pc=0. A later redirect to 5 fetches 5 while addr_err remains 1.
- halt=1 for 4 cycles with out_ready=1: the buffer drains and out_valid drops. halt=0 resumes at the held pc. rst asserted mid-stream: out_valid=0 immediately and pc=0.
